// File: rtl/mtr_seq_pkg.sv
// Shared types, widths and the duty saturation helper for the motor command sequencer.
package mtr_seq_pkg;

  localparam int PWM_W = 11;
  localparam int CMD_W = 12;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    RAMP_DN = 2'd2,
    DEAD    = 2'd3
  } mtr_state_t;

  // |cmd| clamped to max_duty; the -2048 corner lands on max_duty as well
  function automatic logic [PWM_W-1:0] sat_mag(input logic [CMD_W-1:0] cmd,
                                               input logic [PWM_W-1:0] max_duty);
    logic [CMD_W-1:0] abs_v;
    abs_v = cmd[CMD_W-1] ? (~cmd + 12'd1) : cmd;
    if (abs_v > {1'b0, max_duty}) begin
      sat_mag = max_duty;
    end else begin
      sat_mag = abs_v[PWM_W-1:0];
    end
  endfunction

endpackage

// File: rtl/mtr_seq_if.sv
// Command/drive bundle between balance controller (master) and sequencer (slave).
interface mtr_seq_if;
  import mtr_seq_pkg::*;

  logic             en;
  logic             fault;
  logic             cmd_vld;
  logic [CMD_W-1:0] lft_cmd;
  logic [CMD_W-1:0] rght_cmd;
  logic [PWM_W-1:0] lft_spd;
  logic             lft_rev;
  logic [PWM_W-1:0] rght_spd;
  logic             rght_rev;
  logic             busy;

  modport master (
    output en, fault, cmd_vld, lft_cmd, rght_cmd,
    input  lft_spd, lft_rev, rght_spd, rght_rev, busy
  );

  modport slave (
    input  en, fault, cmd_vld, lft_cmd, rght_cmd,
    output lft_spd, lft_rev, rght_spd, rght_rev, busy
  );

endinterface

// File: rtl/mtr_seq_ch.sv
// One wheel channel: target latch, slew limiting and the reversal ramp-down/dead-time FSM.
module mtr_seq_ch import mtr_seq_pkg::*; #(
  parameter int unsigned STEP     = 64,
  parameter int unsigned DEAD_PER = 2,
  parameter int unsigned MAX_DUTY = 2047
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_tick,
  input  logic             i_en,
  input  logic             i_fault,
  input  logic             i_cmd_vld,
  input  logic [CMD_W-1:0] i_cmd,
  output logic [PWM_W-1:0] o_spd,
  output logic             o_rev,
  output logic             o_busy
);

  localparam logic [1:0]       S_IDLE    = 2'(IDLE);
  localparam logic [1:0]       S_RUN     = 2'(RUN);
  localparam logic [1:0]       S_RAMP_DN = 2'(RAMP_DN);
  localparam logic [1:0]       S_DEAD    = 2'(DEAD);
  localparam logic [PWM_W-1:0] STEP_W    = 11'(STEP);
  localparam logic [PWM_W-1:0] MAX_W     = 11'(MAX_DUTY);
  localparam logic [3:0]       DEAD_W    = 4'(DEAD_PER);

  logic [CMD_W-1:0] r_tgt;
  logic [1:0]       r_state;
  logic [PWM_W-1:0] r_spd;
  logic             r_rev;
  logic [3:0]       r_dcnt;
  logic             r_busy;

  logic [PWM_W-1:0] w_mag;
  logic             w_tsgn;
  logic [PWM_W-1:0] w_slew;
  logic [1:0]       w_state_nxt;
  logic [PWM_W-1:0] w_spd_nxt;
  logic             w_rev_nxt;
  logic [3:0]       w_dcnt_nxt;

  // A zero command keeps the current direction so it can never start a reversal
  always_comb begin
    w_mag  = sat_mag(r_tgt, MAX_W);
    w_tsgn = (r_tgt != 12'd0) ? r_tgt[CMD_W-1] : r_rev;
    if (r_spd < w_mag) begin
      w_slew = ((w_mag - r_spd) > STEP_W) ? (r_spd + STEP_W) : w_mag;
    end else begin
      w_slew = ((r_spd - w_mag) > STEP_W) ? (r_spd - STEP_W) : w_mag;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_spd_nxt   = r_spd;
    w_rev_nxt   = r_rev;
    w_dcnt_nxt  = r_dcnt;
    if (i_fault || !i_en) begin
      w_state_nxt = S_IDLE;
      w_spd_nxt   = 11'd0;
    end else if (i_tick) begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_RUN;
          w_spd_nxt   = 11'd0;
        end
        S_RUN, S_RAMP_DN: begin
          if (w_tsgn == r_rev) begin
            w_state_nxt = S_RUN;
            w_spd_nxt   = w_slew;
          end else if (r_spd > STEP_W) begin
            w_state_nxt = S_RAMP_DN;
            w_spd_nxt   = r_spd - STEP_W;
          end else begin
            w_state_nxt = S_DEAD;
            w_spd_nxt   = 11'd0;
            w_dcnt_nxt  = DEAD_W;
          end
        end
        S_DEAD: begin
          w_spd_nxt = 11'd0;
          if (r_dcnt <= 4'd1) begin
            w_state_nxt = S_RUN;
            w_rev_nxt   = w_tsgn;
            w_dcnt_nxt  = 4'd0;
          end else begin
            w_dcnt_nxt  = r_dcnt - 4'd1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_spd_nxt   = 11'd0;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tgt   <= 12'd0;
      r_state <= S_IDLE;
      r_spd   <= 11'd0;
      r_rev   <= 1'b0;
      r_dcnt  <= 4'd0;
      r_busy  <= 1'b0;
    end else begin
      if (i_cmd_vld) begin
        r_tgt <= i_cmd;
      end
      r_state <= w_state_nxt;
      r_spd   <= w_spd_nxt;
      r_rev   <= w_rev_nxt;
      r_dcnt  <= w_dcnt_nxt;
      r_busy  <= (w_state_nxt == S_RAMP_DN) || (w_state_nxt == S_DEAD);
    end
  end

  assign o_spd  = r_spd;
  assign o_rev  = r_rev;
  assign o_busy = r_busy;

endmodule

// File: rtl/mtr_seq.sv
// Motor command sequencer top: PWM-period counter shared by two independent wheel channels.
module mtr_seq import mtr_seq_pkg::*; #(
  parameter int unsigned STEP     = 64,
  parameter int unsigned DEAD_PER = 2,
  parameter int unsigned MAX_DUTY = 2047
) (
  input logic        clk,
  input logic        rst_n,
  mtr_seq_if.slave   bus
);

  logic [PWM_W-1:0] r_cnt;
  logic             w_tick;
  logic             w_lft_busy;
  logic             w_rght_busy;

  // Updates land on the last clock of the period so new duty is seen from cnt == 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 11'd0;
    end else begin
      r_cnt <= r_cnt + 11'd1;
    end
  end

  assign w_tick = (r_cnt == 11'd2047);

  mtr_seq_ch #(.STEP(STEP), .DEAD_PER(DEAD_PER), .MAX_DUTY(MAX_DUTY)) u_lft (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_tick    (w_tick),
    .i_en      (bus.en),
    .i_fault   (bus.fault),
    .i_cmd_vld (bus.cmd_vld),
    .i_cmd     (bus.lft_cmd),
    .o_spd     (bus.lft_spd),
    .o_rev     (bus.lft_rev),
    .o_busy    (w_lft_busy)
  );

  mtr_seq_ch #(.STEP(STEP), .DEAD_PER(DEAD_PER), .MAX_DUTY(MAX_DUTY)) u_rght (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_tick    (w_tick),
    .i_en      (bus.en),
    .i_fault   (bus.fault),
    .i_cmd_vld (bus.cmd_vld),
    .i_cmd     (bus.rght_cmd),
    .o_spd     (bus.rght_spd),
    .o_rev     (bus.rght_rev),
    .o_busy    (w_rght_busy)
  );

  assign bus.busy = w_lft_busy | w_rght_busy;

endmodule

// File: tb/tb_mtr_seq.sv
// Scoreboard bench for mtr_seq: directed commands queue expected per-period outputs, a monitor checks them.
module tb_mtr_seq;

  typedef struct {
    logic [10:0] ls;
    logic        lr;
    logic [10:0] rs;
    logic        rr;
    logic        b;
    string       nm;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] tb_cnt = 11'd0;
  logic        wrapped = 1'b0;
  exp_t        q[$];
  logic [24:0] last = 25'd0;
  logic        have_last = 1'b0;
  int          total = 0;
  int          bad = 0;
  int          req = 0;
  int          rseen = 0;
  int          areq = 0;
  int          aseen = 0;
  int          ld[11] = '{236, 172, 108, 44, 0, 0, 0, 64, 128, 192, 200};

  mtr_seq_if bus();

  mtr_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Independent model of the PWM period: flags the cycle right after each 2047 edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tb_cnt  <= 11'd0;
      wrapped <= 1'b0;
    end else begin
      tb_cnt  <= tb_cnt + 11'd1;
      wrapped <= (tb_cnt == 11'd2047);
    end
  end

  function automatic int rsp(input int t);
    int v;
    if (t < 5) return 0;
    v = 64 * (t - 4);
    return (v > 2047) ? 2047 : v;
  endfunction

  task automatic ex(input int ls, input int lr, input int rs, input int rr, input int b, input string nm);
    exp_t e;
    e.ls = 11'(ls);
    e.lr = 1'(lr);
    e.rs = 11'(rs);
    e.rr = 1'(rr);
    e.b  = 1'(b);
    e.nm = nm;
    q.push_back(e);
  endtask

  task automatic chk_pop();
    exp_t e;
    logic [24:0] act;
    logic [24:0] want;
    act = {bus.lft_spd, bus.lft_rev, bus.rght_spd, bus.rght_rev, bus.busy};
    total++;
    if (q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_update: got %h, expected no update", act);
    end else begin
      e = q.pop_front();
      want = {e.ls, e.lr, e.rs, e.rr, e.b};
      last = want;
      have_last = 1'b1;
      if (act !== want) begin
        bad++;
        $display("FAIL %s: got lspd=%0d lrev=%0d rspd=%0d rrev=%0d busy=%0d, expected lspd=%0d lrev=%0d rspd=%0d rrev=%0d busy=%0d",
                 e.nm, bus.lft_spd, bus.lft_rev, bus.rght_spd, bus.rght_rev, bus.busy,
                 e.ls, e.lr, e.rs, e.rr, e.b);
      end
    end
  endtask

  // Monitor: pops on every period update, on explicit requests and on async reset; mid-period hold check
  initial begin
    forever begin
      @(negedge clk or negedge rst_n);
      if (areq != aseen) begin
        aseen = areq;
        #1;
        chk_pop();
      end else if (!clk) begin
        if (wrapped || (req != rseen)) begin
          rseen = req;
          chk_pop();
        end else if (rst_n && have_last && tb_cnt == 11'd1024) begin
          total++;
          if ({bus.lft_spd, bus.lft_rev, bus.rght_spd, bus.rght_rev, bus.busy} !== last) begin
            bad++;
            $display("FAIL mid_period_hold: got %h, expected %h",
                     {bus.lft_spd, bus.lft_rev, bus.rght_spd, bus.rght_rev, bus.busy}, last);
          end
        end
      end
    end
  end

  task automatic send(input int l, input int r);
    @(negedge clk);
    bus.cmd_vld  = 1'b1;
    bus.lft_cmd  = 12'(l);
    bus.rght_cmd = 12'(r);
    @(negedge clk);
    bus.cmd_vld  = 1'b0;
  endtask

  task automatic drain();
    int lim;
    int k;
    lim = (q.size() + 1) * 2100;
    k = 0;
    while (q.size() != 0 && k < lim) begin
      @(negedge clk);
      k++;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d entries pending, expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    bus.en       = 1'b1;
    bus.fault    = 1'b0;
    bus.cmd_vld  = 1'b0;
    bus.lft_cmd  = 12'd0;
    bus.rght_cmd = 12'd0;
    repeat (3) @(negedge clk);
    ex(0, 0, 0, 0, 0, "reset_state");
    @(posedge clk);
    #1 req++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // right channel saturates from rest (DEAD first since rev must flip), left ramps to +300
    ex(0, 0, 0, 0, 0, "t1_idle_to_run");
    ex(64, 0, 0, 0, 1, "t2_ramp");
    ex(128, 0, 0, 0, 1, "t3_ramp");
    ex(192, 0, 0, 1, 0, "t4_ramp");
    ex(256, 0, 64, 1, 0, "t5_ramp");
    ex(300, 0, 128, 1, 0, "t6_clamp");
    send(300, -2048);
    drain();

    ex(236, 0, rsp(7), 1, 1, "t7_rampdn");
    ex(172, 0, rsp(8), 1, 1, "t8_rampdn");
    send(-200, -2048);
    drain();

    ex(236, 0, rsp(9), 1, 0, "t9_revert");
    ex(300, 0, rsp(10), 1, 0, "t10_revert");
    send(300, -2048);
    drain();

    for (int i = 0; i < 11; i++) begin
      ex(ld[i], (11 + i >= 17) ? 1 : 0, rsp(11 + i), 1, (11 + i <= 16) ? 1 : 0, "reversal");
    end
    send(-200, -2048);
    drain();

    for (int t = 22; t <= 36; t++) begin
      ex((t <= 26) ? 200 + 64 * (t - 21) : 564, 1, rsp(t), 1, 0, "sat_ramp");
    end
    send(-564, -2048);
    drain();

    ex(500, 1, 1983, 1, 0, "t37_zero_cmd");
    send(-100, 0);
    drain();

    repeat (100) @(negedge clk);
    ex(0, 1, 0, 1, 0, "fault_coast");
    bus.fault = 1'b1;
    @(posedge clk);
    #1 req++;
    repeat (10) @(negedge clk);
    bus.fault = 1'b0;
    ex(0, 1, 0, 1, 0, "t38_restart");
    ex(64, 1, 0, 1, 1, "t39_run_dead");
    send(-100, 100);
    drain();

    repeat (300) @(negedge clk);
    #2;
    ex(0, 0, 0, 0, 0, "async_reset");
    areq++;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b1;
    ex(0, 0, 0, 0, 0, "post_rst_t1");
    ex(64, 0, 0, 0, 0, "post_rst_t2");
    send(100, 0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
